victim_writeback_buffer: RTL and testbench
==========================================

Name: victim_writeback_buffer

Overview:
- Consumer side of the cache's LRU victim output: accepts evicted lines (index + full line data) and queues them in a small FIFO.
- Drains each queued line to memory as a multi-beat write burst over a valid/ready handshake.
- Provides a combinational lookup so a cache miss can be served from a pending victim before memory is updated.
- Sits between the cache/LRU eviction path and the memory write port.

Parameters:
DEPTH, 4, number of victim entries; must be a power of 2 and at least 2
IDX_W, 10, cache line index width
WORD_WID, 64, bits per memory beat
WORDS_PER_LINE, 4, beats per cache line; must be a power of 2 and at least 2

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous, active-high reset
evict_valid_i  input  1  eviction request from cache
evict_ready_o  output  1  buffer can accept an eviction
evict_idx_i  input  IDX_W  evicted line index
evict_data_i  input  WORDS_PER_LINE*WORD_WID  evicted line; beat 0 in the LSBs
lookup_valid_i  input  1  probe request
lookup_idx_i  input  IDX_W  probe index
lookup_hit_o  output  1  probe matches a pending entry
lookup_data_o  output  WORDS_PER_LINE*WORD_WID  line data of the matching entry, zero if no hit
mem_valid_o  output  1  write beat valid
mem_ready_i  input  1  memory accepts the beat
mem_idx_o  output  IDX_W  index of the line being written
mem_data_o  output  WORD_WID  current beat data
mem_last_o  output  1  final beat of the line
count_o  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (synchronous, rst_i high at a clock edge):
  - count, read/write pointers, beat counter and all entry valid bits go to 0; FSM goes to IDLE.
  - Outputs after reset: mem_valid_o=0, mem_last_o=0, mem_idx_o=0, mem_data_o=0, lookup_hit_o=0, count_o=0, evict_ready_o=1.
  - Reset mid-burst discards all entries; no further beats are issued.
- Enqueue:
  - Occurs on evict_valid_i && evict_ready_o.
  - The entry is written at the write pointer, which wraps modulo DEPTH.
  - evict_ready_o = (count != DEPTH), decoded from registered state. There is no bypass when full.
  - Duplicate indices are allowed; each duplicate is a separate entry and is written back in FIFO order.
- Drain FSM, states IDLE and BURST:
  - IDLE -> BURST on the edge after count becomes nonzero. Beat counter is 0.
  - In BURST:
    - mem_valid_o=1.
    - mem_idx_o = head index.
    - mem_data_o = head line slice [beat*WORD_WID +: WORD_WID].
    - mem_last_o = (beat == WORDS_PER_LINE-1).
  - Outputs hold stable while mem_ready_i=0.
  - Beat counter increments on mem_valid_o && mem_ready_i.
  - On acceptance of the last beat:
    - Pop the head: clear its valid bit, advance the read pointer, reset the beat counter.
    - If count after the update is nonzero, stay in BURST with the next head presented on the next cycle. Back-to-back bursts have no idle cycle.
    - Otherwise return to IDLE.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
  - When full, evict_ready_o stays 0 during the pop cycle. Ready rises the following cycle.
- Lookup (combinational, same cycle):
  - Compare lookup_idx_i against all valid entries, gated by lookup_valid_i.
  - On multiple matches, the youngest entry (closest behind the write pointer) wins.
  - The head currently mid-burst still hits until its last beat is accepted.
  - An entry being enqueued in the same cycle is not visible until the next cycle.
- Width and arithmetic:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - Beat counter is $clog2(WORDS_PER_LINE) bits.
  - count never exceeds DEPTH or underflows.

Decomposition:
- Package victim_pkg:
  - Entry struct {valid, idx, line}.
  - FSM state enum {IDLE, BURST}.
  - Width localparams derived from the parameters.
- Sub-module victim_lookup: combinational youngest-match priority search over the entry array. Returns hit and slot number.
- FIFO storage and FSM remain in the top module.

Test Plan:
- Reset, then single evict (idx=0x05, line words 0x11/0x22/0x33/0x44) with mem_ready_i=1 -> one cycle after enqueue, 4 consecutive beats with data 0x11..0x44, mem_idx_o=0x05, mem_last_o on the 4th beat, count_o returns to 0.
- Fill with mem_ready_i=0: 4 evicts (idx 1,2,3,4) -> count_o=4, evict_ready_o=0, a 5th evict is not accepted. mem_valid_o=1 with beat 0 of idx 1 held stable.
- Backpressure: toggle mem_ready_i every cycle -> each beat is held until accepted, no beat lost or duplicated. Lines drain in order 1,2,3,4 with no idle cycle between bursts.
- Lookup: enqueue idx 0x2A (line A) then idx 0x2A (line B), probe 0x2A -> lookup_hit_o=1, lookup_data_o=B. Probe 0x2B -> hit=0, data=0. During the burst of line A, probe still hits B.
- Full with simultaneous pop: full buffer, last beat accepted while evict_valid_i=1 -> no enqueue that cycle, count_o=3 next cycle, then the evict is accepted and count_o=4.
- Reset asserted during beat 2 of a burst -> next cycle mem_valid_o=0, count_o=0, evict_ready_o=1, lookups miss.

Source files
------------

// File: rtl/victim_pkg.sv
// Shared types and default sizing for the victim writeback buffer.
package victim_pkg;

   localparam int DEPTH_DEF          = 4;
   localparam int IDX_W_DEF          = 10;
   localparam int WORD_WID_DEF       = 64;
   localparam int WORDS_PER_LINE_DEF = 4;
   localparam int LINE_W_DEF         = WORDS_PER_LINE_DEF * WORD_WID_DEF;
   localparam int PTR_W_DEF          = $clog2(DEPTH_DEF);
   localparam int BEAT_W_DEF         = $clog2(WORDS_PER_LINE_DEF);
   localparam int CNT_W_DEF          = $clog2(DEPTH_DEF + 1);

   // One victim slot at the default sizing: occupancy flag, line index, line data.
   typedef struct packed {
      logic                  valid;
      logic [IDX_W_DEF-1:0]  idx;
      logic [LINE_W_DEF-1:0] line;
   } entry_t;

   // Drain state: IDLE waits for an occupied slot, BURST streams the head line.
   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

endpackage

// File: rtl/victim_writeback_buffer_lookup.sv
// Youngest-match search over the victim slots for a probe index.
module victim_writeback_buffer_lookup
   import victim_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int IDX_W = IDX_W_DEF,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] slot_valid,
   input  logic [IDX_W-1:0] slot_idx [DEPTH],
   input  logic [PTR_W-1:0] wr_ptr,
   input  logic             lookup_valid,
   input  logic [IDX_W-1:0] lookup_idx,
   output logic             hit,
   output logic [PTR_W-1:0] slot
);

   logic [PTR_W-1:0] probe_slot;

   // Walk from the oldest position (at wr_ptr) to the youngest (wr_ptr-1); later matches override.
   always_comb begin
      hit        = 1'b0;
      slot       = '0;
      probe_slot = '0;
      if (lookup_valid) begin
         for (int k = DEPTH; k >= 1; k--) begin
            probe_slot = wr_ptr - PTR_W'(k);
            if (slot_valid[probe_slot] && (slot_idx[probe_slot] == lookup_idx)) begin
               hit  = 1'b1;
               slot = probe_slot;
            end
         end
      end
   end

endmodule

// File: rtl/victim_writeback_buffer.sv
// Victim line FIFO with multi-beat memory drain and same-cycle victim lookup.
//   state | meaning
//   IDLE  | no burst in flight; leaves on the edge after the buffer becomes non-empty
//   BURST | presenting the head line beat by beat to memory
module victim_writeback_buffer
   import victim_pkg::*;
#(
   parameter int DEPTH          = DEPTH_DEF,
   parameter int IDX_W          = IDX_W_DEF,
   parameter int WORD_WID       = WORD_WID_DEF,
   parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               evict_valid_i,
   output logic                               evict_ready_o,
   input  logic [IDX_W-1:0]                   evict_idx_i,
   input  logic [WORDS_PER_LINE*WORD_WID-1:0] evict_data_i,
   input  logic                               lookup_valid_i,
   input  logic [IDX_W-1:0]                   lookup_idx_i,
   output logic                               lookup_hit_o,
   output logic [WORDS_PER_LINE*WORD_WID-1:0] lookup_data_o,
   output logic                               mem_valid_o,
   input  logic                               mem_ready_i,
   output logic [IDX_W-1:0]                   mem_idx_o,
   output logic [WORD_WID-1:0]                mem_data_o,
   output logic                               mem_last_o,
   output logic [$clog2(DEPTH+1)-1:0]         count_o
);

   localparam int LINE_W = WORDS_PER_LINE * WORD_WID;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int BEAT_W = $clog2(WORDS_PER_LINE);
   localparam int CNT_W  = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS_PER_LINE - 1);

   logic [DEPTH-1:0]  valid_q;
   logic [IDX_W-1:0]  idx_q  [DEPTH];
   logic [LINE_W-1:0] line_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_nxt;
   logic [BEAT_W-1:0] beat_q;
   state_t            state_q;

   logic              bursting;
   logic              push;
   logic              beat_accept;
   logic              pop;
   logic              hit;
   logic [PTR_W-1:0]  hit_slot;

   assign bursting      = (state_q == BURST);
   assign evict_ready_o = (count_q != CNT_FULL);
   assign push          = evict_valid_i && evict_ready_o;
   assign beat_accept   = bursting && mem_ready_i;
   assign pop           = beat_accept && (beat_q == BEAT_LAST);
   assign count_o       = count_q;

   assign mem_valid_o = bursting;
   assign mem_idx_o   = bursting ? idx_q[rd_ptr_q] : '0;
   assign mem_data_o  = bursting ? line_q[rd_ptr_q][WORD_WID*int'(beat_q) +: WORD_WID] : '0;
   assign mem_last_o  = bursting && (beat_q == BEAT_LAST);

   // Occupancy after this cycle's push and pop.
   always_comb begin
      count_nxt = count_q;
      case ({push, pop})
         2'b10:   count_nxt = count_q + CNT_W'(1);
         2'b01:   count_nxt = count_q - CNT_W'(1);
         default: count_nxt = count_q;
      endcase
   end

   // Pointers, occupancy, beat counter and drain FSM.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_nxt;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case (state_q)
            IDLE: begin
               beat_q <= '0;
               if (count_q != '0) state_q <= BURST;
            end
            BURST: begin
               if (pop) begin
                  beat_q <= '0;
                  if (count_nxt == '0) state_q <= IDLE;
               end else if (beat_accept) begin
                  beat_q <= beat_q + BEAT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               beat_q  <= '0;
            end
         endcase
      end
   end

   // Slot valid bits: a pop never targets the slot being pushed since the buffer is not full then.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else begin
         if (pop)  valid_q[rd_ptr_q] <= 1'b0;
         if (push) valid_q[wr_ptr_q] <= 1'b1;
      end
   end

   // Slot payload; qualified by valid_q so no reset needed.
   always_ff @(posedge clk_i) begin
      if (push) begin
         idx_q[wr_ptr_q]  <= evict_idx_i;
         line_q[wr_ptr_q] <= evict_data_i;
      end
   end

   victim_writeback_buffer_lookup #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W),
      .PTR_W (PTR_W)
   ) u_lookup (
      .slot_valid   (valid_q),
      .slot_idx     (idx_q),
      .wr_ptr       (wr_ptr_q),
      .lookup_valid (lookup_valid_i),
      .lookup_idx   (lookup_idx_i),
      .hit          (hit),
      .slot         (hit_slot)
   );

   assign lookup_hit_o  = hit;
   assign lookup_data_o = hit ? line_q[hit_slot] : '0;

endmodule

// File: tb/tb_victim_writeback_buffer.sv
// Self-checking bench for victim_writeback_buffer (default parameters).
module tb_victim_writeback_buffer;

   localparam int DEPTH = 4;
   localparam int WPL   = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         ev;
   logic         ready;
   logic [9:0]   eidx;
   logic [255:0] eline;
   logic         lv;
   logic [9:0]   lidx;
   logic         hit;
   logic [255:0] ldata;
   logic         mv;
   logic         mr;
   logic [9:0]   midx;
   logic [63:0]  mdata;
   logic         mlast;
   logic [2:0]   count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   victim_writeback_buffer dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .evict_valid_i  (ev),
      .evict_ready_o  (ready),
      .evict_idx_i    (eidx),
      .evict_data_i   (eline),
      .lookup_valid_i (lv),
      .lookup_idx_i   (lidx),
      .lookup_hit_o   (hit),
      .lookup_data_o  (ldata),
      .mem_valid_o    (mv),
      .mem_ready_i    (mr),
      .mem_idx_o      (midx),
      .mem_data_o     (mdata),
      .mem_last_o     (mlast),
      .count_o        (count)
   );

   // Reference model: a queue of pending lines plus the beat position of the head.
   typedef struct {
      logic [9:0]   idx;
      logic [255:0] line;
   } ent_t;

   typedef struct {
      logic [9:0]  idx;
      logic [63:0] data;
   } beat_t;

   ent_t  q[$];
   bit    burst;
   int    beat;
   beat_t accq[$];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] mk_line(input int k);
      return {64'(k * 16 + 4), 64'(k * 16 + 3), 64'(k * 16 + 2), 64'(k * 16 + 1)};
   endfunction

   task automatic model_check();
      logic [255:0] l;
      logic [63:0]  exp_md;
      logic [9:0]   exp_midx;
      logic         exp_hit;
      logic [255:0] exp_ld;
      exp_md   = '0;
      exp_midx = '0;
      if (burst) begin
         l        = q[0].line;
         exp_md   = l[beat*64 +: 64];
         exp_midx = q[0].idx;
      end
      exp_hit = 1'b0;
      exp_ld  = '0;
      if (lv) begin
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].idx == lidx) begin
               exp_hit = 1'b1;
               exp_ld  = q[i].line;
               break;
            end
         end
      end
      chk("m_count", count, q.size());
      chk("m_ready", ready, q.size() != DEPTH);
      chk("m_valid", mv, burst);
      chk("m_idx", midx, exp_midx);
      chk("m_data", mdata, exp_md);
      chk("m_last", mlast, burst && (beat == WPL - 1));
      chk("m_hit", hit, exp_hit);
      chk("m_ldata", ldata, exp_ld);
   endtask

   task automatic model_update();
      int   old_size;
      bit   acc;
      bit   pushed;
      ent_t e;
      old_size = q.size();
      acc      = burst && mr;
      pushed   = ev && (old_size != DEPTH);
      if (rst) begin
         q.delete();
         burst = 0;
         beat  = 0;
      end else begin
         if (acc) begin
            if (beat == WPL - 1) begin
               void'(q.pop_front());
               beat = 0;
            end else begin
               beat++;
            end
         end
         if (pushed) begin
            e.idx  = eidx;
            e.line = eline;
            q.push_back(e);
         end
         if (burst) burst = (q.size() != 0);
         else       burst = (old_size != 0);
      end
   endtask

   // One clock: check against the model, record accepted beats, clock, update model.
   task automatic cycle();
      beat_t b;
      #1;
      model_check();
      if (mv && mr) begin
         b.idx  = midx;
         b.data = mdata;
         accq.push_back(b);
      end
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; ev = 1'b0; mr = 1'b0; lv = 1'b0;
      cycle();
      rst = 1'b0;
   endtask

   task automatic push_line(input logic [9:0] i, input logic [255:0] l);
      ev = 1'b1; eidx = i; eline = l;
      cycle();
      ev = 1'b0;
   endtask

   typedef struct {
      logic         ev;
      logic [9:0]   eidx;
      logic         mr;
      logic         lv;
      logic [9:0]   lidx;
      logic [2:0]   e_count;
      logic         e_ready;
      logic         e_mv;
      logic [9:0]   e_midx;
      logic [63:0]  e_mdata;
      logic         e_last;
      logic         e_hit;
   } vec_t;

   vec_t tbl[7];

   initial begin
      // Single line drains as four back-to-back beats one cycle after enqueue.
      tbl[0] = '{1'b1, 10'h05, 1'b1, 1'b0, 10'h05, 3'd0, 1'b1, 1'b0, 10'h00, 64'h00, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 10'h00, 1'b1, 1'b1, 10'h05, 3'd1, 1'b1, 1'b0, 10'h00, 64'h00, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 10'h00, 1'b1, 1'b1, 10'h05, 3'd1, 1'b1, 1'b1, 10'h05, 64'h11, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 10'h00, 1'b1, 1'b1, 10'h05, 3'd1, 1'b1, 1'b1, 10'h05, 64'h22, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 10'h00, 1'b1, 1'b1, 10'h05, 3'd1, 1'b1, 1'b1, 10'h05, 64'h33, 1'b0, 1'b1};
      tbl[5] = '{1'b0, 10'h00, 1'b1, 1'b1, 10'h05, 3'd1, 1'b1, 1'b1, 10'h05, 64'h44, 1'b1, 1'b1};
      tbl[6] = '{1'b0, 10'h00, 1'b1, 1'b1, 10'h05, 3'd0, 1'b1, 1'b0, 10'h00, 64'h00, 1'b0, 1'b0};

      rst = 1'b1; ev = 1'b0; eidx = '0; eline = '0; lv = 1'b0; lidx = '0; mr = 1'b0;
      repeat (2) @(posedge clk);
      q.delete(); burst = 0; beat = 0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready", ready, 1'b1);
      chk("rst_valid", mv, 1'b0);
      chk("rst_count", count, 3'd0);
      chk("rst_last", mlast, 1'b0);
      chk("rst_idx", midx, 10'h0);
      chk("rst_data", mdata, 64'h0);
      chk("rst_hit", hit, 1'b0);

      // Table-driven single-line burst.
      for (int i = 0; i < 7; i++) begin
         ev = tbl[i].ev; eidx = tbl[i].eidx; eline = {64'h44, 64'h33, 64'h22, 64'h11};
         mr = tbl[i].mr; lv = tbl[i].lv; lidx = tbl[i].lidx;
         #1;
         chk("t_count", count, tbl[i].e_count);
         chk("t_ready", ready, tbl[i].e_ready);
         chk("t_valid", mv, tbl[i].e_mv);
         chk("t_idx", midx, tbl[i].e_midx);
         chk("t_data", mdata, tbl[i].e_mdata);
         chk("t_last", mlast, tbl[i].e_last);
         chk("t_hit", hit, tbl[i].e_hit);
         cycle();
      end
      ev = 1'b0; lv = 1'b0;

      // Fill under backpressure, refuse a fifth eviction, then drain with toggling ready.
      do_reset();
      for (int k = 1; k <= 4; k++) push_line(10'(k), mk_line(k));
      ev = 1'b1; eidx = 10'h05; eline = mk_line(5);
      #1;
      chk("full_count", count, 3'd4);
      chk("full_ready", ready, 1'b0);
      chk("full_valid", mv, 1'b1);
      chk("full_idx", midx, 10'h001);
      chk("full_data", mdata, 64'h11);
      cycle();
      ev = 1'b0;
      #1;
      chk("full_nopush", count, 3'd4);
      chk("full_hold", mdata, 64'h11);
      accq.delete();
      for (int n = 0; n < 80 && (count != 0 || mv); n++) begin
         mr = n[0];
         cycle();
      end
      chk("bp_drained", count, 3'd0);
      chk("bp_beats", accq.size(), 16);
      for (int k = 0; k < 16 && k < accq.size(); k++) begin
         chk("bp_idx", accq[k].idx, 10'(k / 4 + 1));
         chk("bp_data", accq[k].data, 64'((k / 4 + 1) * 16 + (k % 4) + 1));
      end

      // Duplicate indices: youngest wins; same-cycle enqueue invisible; head mid-burst still hits.
      do_reset();
      lv = 1'b1; lidx = 10'h2A;
      ev = 1'b1; eidx = 10'h2A; eline = mk_line(10);
      #1;
      chk("lk_samecyc", hit, 1'b0);
      cycle();
      push_line(10'h2A, mk_line(11));
      #1;
      chk("lk_hit", hit, 1'b1);
      chk("lk_young", ldata, mk_line(11));
      cycle();
      lidx = 10'h2B;
      #1;
      chk("lk_miss", hit, 1'b0);
      chk("lk_missdata", ldata, 256'h0);
      cycle();
      lidx = 10'h2A; mr = 1'b1;
      for (int b = 0; b < 4; b++) begin
         #1;
         chk("lk_burst_idx", midx, 10'h2A);
         chk("lk_burst_data", mdata, 64'(10 * 16 + b + 1));
         chk("lk_burst_hit", ldata, mk_line(11));
         cycle();
      end
      lv = 1'b0; mr = 1'b0;

      // Full buffer: last beat accepted while evicting -> refused this cycle, taken the next.
      do_reset();
      for (int k = 1; k <= 4; k++) push_line(10'(16 + k), mk_line(k));
      mr = 1'b1;
      repeat (3) cycle();
      ev = 1'b1; eidx = 10'h035; eline = mk_line(7);
      #1;
      chk("fp_ready", ready, 1'b0);
      chk("fp_last", mlast, 1'b1);
      chk("fp_count", count, 3'd4);
      cycle();
      mr = 1'b0;
      #1;
      chk("fp_count_dec", count, 3'd3);
      chk("fp_ready_up", ready, 1'b1);
      cycle();
      ev = 1'b0; lv = 1'b1; lidx = 10'h035;
      #1;
      chk("fp_count_full", count, 3'd4);
      chk("fp_new_hit", hit, 1'b1);
      cycle();
      lv = 1'b0;

      // Reset during beat 2 of a burst.
      do_reset();
      mr = 1'b1;
      push_line(10'h09, mk_line(9));
      repeat (3) cycle();
      #1;
      chk("rb_beat2", mdata, 64'(9 * 16 + 3));
      rst = 1'b1;
      cycle();
      rst = 1'b0; lv = 1'b1; lidx = 10'h09;
      #1;
      chk("rb_valid", mv, 1'b0);
      chk("rb_count", count, 3'd0);
      chk("rb_ready", ready, 1'b1);
      chk("rb_hit", hit, 1'b0);
      cycle();

      // Randomised traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         rst   = ($urandom_range(0, 199) == 0);
         ev    = $urandom_range(0, 1);
         eidx  = 10'h3C + 10'($urandom_range(0, 3));
         eline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         mr    = ($urandom_range(0, 2) != 0);
         lv    = $urandom_range(0, 1);
         lidx  = 10'h3C + 10'($urandom_range(0, 4));
         cycle();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
